// File: rtl/wash_ctrl_if.sv
// Washer panel bus: operator inputs (start, pause, door_open) toward the
// sequencer and the display/LED outputs back toward the panel.
interface wash_ctrl_if;
  logic       start;
  logic       pause;
  logic       door_open;
  logic [3:0] dig2;
  logic [3:0] dig1;
  logic [3:0] dig0;
  logic [3:0] level;
  logic [2:0] phase;
  logic [7:0] st_light;
  logic       busy;
  logic       done;
  logic       alarm;

  // Panel side: drives operator inputs, reads the display.
  modport master (
    output start, pause, door_open,
    input  dig2, dig1, dig0, level, phase, st_light, busy, done, alarm
  );

  // Sequencer side.
  modport slave (
    input  start, pause, door_open,
    output dig2, dig1, dig0, level, phase, st_light, busy, done, alarm
  );
endinterface

// File: rtl/wash_ctrl.sv
// Wash-cycle sequencer: FILL -> WASH -> [RINSE] -> DRAIN -> SPIN -> DONE.
// Keeps a 3-digit BCD countdown of remaining seconds, a water level and a
// thermometer phase bar. pause and door_open freeze the 1 s prescaler in
// place, so a partial second resumes where it stopped.
// Optional feature macro: WASH_RINSE_EN inserts the RINSE phase.
module wash_ctrl #(
  parameter int CLKS_PER_SEC = 100000000,
  parameter int FILL_S       = 10,
  parameter int WASH_S       = 40,
  parameter int RINSE_S      = 20,
  parameter int DRAIN_S      = 10,
  parameter int SPIN_S       = 20,
  parameter int LEVEL_MAX    = 9
) (
  input  logic        clk,
  input  logic        rst,
  wash_ctrl_if.slave  bus
);

`ifdef WASH_RINSE_EN
  localparam bit RINSE_EN = 1'b1;
`else
  localparam bit RINSE_EN = 1'b0;
`endif

  localparam int RINSE_USED = RINSE_EN ? RINSE_S : 0;
  localparam int TOTAL      = FILL_S + WASH_S + RINSE_USED + DRAIN_S + SPIN_S;

  // The display only has three BCD digits.
  if (TOTAL > 999) begin : g_total_check
    $error("wash_ctrl: total cycle time %0d s does not fit in 3 BCD digits", TOTAL);
  end

  localparam int TW = 10;
  localparam int PW = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(CLKS_PER_SEC - 1);
  localparam logic [3:0]    LVL_MAX    = 4'(LEVEL_MAX);
  localparam logic [3:0]    TOT_D2     = 4'(TOTAL / 100);
  localparam logic [3:0]    TOT_D1     = 4'((TOTAL / 10) % 10);
  localparam logic [3:0]    TOT_D0     = 4'(TOTAL % 10);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    WASH  = 3'd2,
    RINSE = 3'd3,
    DRAIN = 3'd4,
    SPIN  = 3'd5,
    DONE  = 3'd6
  } phase_t;

  // Seconds spent in a phase; DONE/IDLE carry no timer.
  function automatic logic [TW-1:0] dur_of(input phase_t p);
    case (p)
      FILL:    dur_of = TW'(FILL_S);
      WASH:    dur_of = TW'(WASH_S);
      RINSE:   dur_of = TW'(RINSE_S);
      DRAIN:   dur_of = TW'(DRAIN_S);
      SPIN:    dur_of = TW'(SPIN_S);
      default: dur_of = '0;
    endcase
  endfunction

  // Phase that follows p when its timer expires.
  function automatic phase_t next_of(input phase_t p);
    case (p)
      FILL:    next_of = WASH;
      WASH:    next_of = RINSE_EN ? RINSE : DRAIN;
      RINSE:   next_of = DRAIN;
      DRAIN:   next_of = SPIN;
      SPIN:    next_of = DONE;
      default: next_of = p;
    endcase
  endfunction

  phase_t        phase_q, phase_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    d2_q, d2_d, d1_q, d1_d, d0_q, d0_d;
  logic [3:0]    level_q, level_d;
  logic [7:0]    st_q, st_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          alarm_q, alarm_d;
  logic          run;
  logic          tick;

  assign run  = busy_q & ~bus.pause & ~bus.door_open;
  assign tick = run && (presc_q == PRESC_LAST);

  // State register: every output is a flop, with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops
    // sample the pre-edge values regardless of statement order.
    if (rst) begin
      phase_q <= IDLE;
      timer_q <= '0;
      presc_q <= '0;
      d2_q    <= TOT_D2;
      d1_q    <= TOT_D1;
      d0_q    <= TOT_D0;
      level_q <= '0;
      st_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      timer_q <= timer_d;
      presc_q <= presc_d;
      d2_q    <= d2_d;
      d1_q    <= d1_d;
      d0_q    <= d0_d;
      level_q <= level_d;
      st_q    <= st_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      alarm_q <= alarm_d;
    end
  end

  // Next-state logic: start/restart, prescaler, per-second countdown,
  // level update and phase sequencing.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path through
    // the case/if tree can infer a latch.
    phase_d = phase_q;
    timer_d = timer_q;
    presc_d = presc_q;
    d2_d    = d2_q;
    d1_d    = d1_q;
    d0_d    = d0_q;
    level_d = level_q;
    alarm_d = busy_q & bus.door_open;

    case (phase_q)
      IDLE, DONE: begin
        if (bus.start && !bus.door_open) begin
          phase_d = FILL;
          timer_d = dur_of(FILL);
          presc_d = '0;
          d2_d    = TOT_D2;
          d1_d    = TOT_D1;
          d0_d    = TOT_D0;
          level_d = '0;
        end
      end
      default: begin
        if (tick) begin
          presc_d = '0;
          // BCD countdown with borrow; the last tick lands exactly on 000.
          if (d0_q != 4'd0) begin
            d0_d = d0_q - 4'd1;
          end else begin
            d0_d = 4'd9;
            if (d1_q != 4'd0) begin
              d1_d = d1_q - 4'd1;
            end else begin
              d1_d = 4'd9;
              d2_d = d2_q - 4'd1;
            end
          end
          case (phase_q)
            FILL:    if (level_q != LVL_MAX) level_d = level_q + 4'd1;
            DRAIN:   if (level_q != 4'd0)    level_d = level_q - 4'd1;
            SPIN:    level_d = '0;
            default: level_d = level_q;
          endcase
          if (timer_q == TW'(1)) begin
            phase_d = next_of(phase_q);
            timer_d = dur_of(phase_d);
            if (phase_d == DONE) level_d = '0;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end else if (run) begin
          presc_d = presc_q + PW'(1);
        end
      end
    endcase

    busy_d = (phase_d != IDLE) && (phase_d != DONE);
    done_d = (phase_d == DONE);
    st_d   = 8'((16'd1 << phase_d) - 16'd1);
  end

  assign bus.phase    = phase_q;
  assign bus.dig2     = d2_q;
  assign bus.dig1     = d1_q;
  assign bus.dig0     = d0_q;
  assign bus.level    = level_q;
  assign bus.st_light = st_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.alarm    = alarm_q;

endmodule

// File: tb/tb_wash_ctrl.sv
// Bench for wash_ctrl. The reference model tracks only the operating mode
// and the number of run-cycles since start; every output is derived from
// that count with plain arithmetic over the phase durations.
module tb_wash_ctrl;
  localparam int CPS  = 4;
  localparam int F    = 3;
  localparam int W    = 2;
  localparam int R    = 2;
  localparam int D    = 3;
  localparam int S    = 2;
  localparam int LMAX = 2;
`ifdef WASH_RINSE_EN
  localparam bit RINSE = 1'b1;
  localparam int W2    = 10;
`else
  localparam bit RINSE = 1'b0;
  localparam int W2    = 30;
`endif
  localparam int TOTAL = F + W + (RINSE ? R : 0) + D + S;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wash_ctrl_if bus ();
  wash_ctrl_if bus2 ();

  wash_ctrl #(
    .CLKS_PER_SEC(CPS), .FILL_S(F), .WASH_S(W), .RINSE_S(R),
    .DRAIN_S(D), .SPIN_S(S), .LEVEL_MAX(LMAX)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  // Second build whose total is exactly 100 s, for the two-digit borrow.
  wash_ctrl #(
    .CLKS_PER_SEC(2), .FILL_S(30), .WASH_S(W2), .RINSE_S(20),
    .DRAIN_S(20), .SPIN_S(20), .LEVEL_MAX(9)
  ) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int tests = 0;
  int fails = 0;

  // Reference model state: 0 idle, 1 running, 2 done.
  int   m_mode = 0;
  int   m_rc   = 0;
  logic m_alarm = 1'b0;

  function automatic int exp_phase(input int s);
    int acc = F;
    if (s < acc) return 1;
    acc += W;
    if (s < acc) return 2;
    if (RINSE) begin
      acc += R;
      if (s < acc) return 3;
    end
    acc += D;
    if (s < acc) return 4;
    acc += S;
    if (s < acc) return 5;
    return 6;
  endfunction

  function automatic int exp_level(input int s);
    int full   = (F < LMAX) ? F : LMAX;
    int dstart = F + W + (RINSE ? R : 0);
    if (s < F) return (s < LMAX) ? s : LMAX;
    if (s < dstart) return full;
    if (s <= dstart + D) return (full > (s - dstart)) ? full - (s - dstart) : 0;
    return 0;
  endfunction

  function automatic void model_edge();
    logic busy_before = (m_mode == 1);
    if (rst) begin
      m_mode  = 0;
      m_rc    = 0;
      m_alarm = 1'b0;
    end else begin
      m_alarm = busy_before & bus.door_open;
      if (m_mode != 1) begin
        if (bus.start && !bus.door_open) begin
          m_mode = 1;
          m_rc   = 0;
        end
      end else if (!bus.pause && !bus.door_open) begin
        m_rc++;
        if (m_rc == TOTAL * CPS) m_mode = 2;
      end
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int s = m_rc / CPS;
    int ph, rem, lv;
    case (m_mode)
      1:       begin ph = exp_phase(s); rem = TOTAL - s; lv = exp_level(s); end
      2:       begin ph = 6;            rem = 0;         lv = 0;            end
      default: begin ph = 0;            rem = TOTAL;     lv = 0;            end
    endcase
    check("phase",    bus.phase,    ph);
    check("dig2",     bus.dig2,     rem / 100);
    check("dig1",     bus.dig1,     (rem / 10) % 10);
    check("dig0",     bus.dig0,     rem % 10);
    check("level",    bus.level,    lv);
    check("st_light", bus.st_light, (1 << ph) - 1);
    check("busy",     bus.busy,     (ph >= 1 && ph <= 5) ? 1 : 0);
    check("done",     bus.done,     (ph == 6) ? 1 : 0);
    check("alarm",    bus.alarm,    m_alarm);
  endtask

  // One clock: model follows the edge, outputs are compared 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    int n;
    int k;
    bit saw3;

    rst = 1'b1;
    bus.start = 1'b0;  bus.pause = 1'b0;  bus.door_open = 1'b0;
    bus2.start = 1'b0; bus2.pause = 1'b0; bus2.door_open = 1'b0;

    // Reset state.
    cycle();
    cycle();
    rst = 1'b0;
    cycle();

    // Full undisturbed cycle; done exactly TOTAL*CPS cycles after start.
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    check("start_busy", bus.busy, 1);
    n = 0;
    saw3 = 1'b0;
    while (!bus.done && n < TOTAL * CPS + 20) begin
      cycle();
      if (bus.phase == 3'd3) saw3 = 1'b1;
      n++;
    end
    check("done_latency", n, TOTAL * CPS);
    check("rinse_seen", saw3, RINSE);
    repeat (3) cycle();

    // start and pause together from DONE: starts, then holds.
    bus.start = 1'b1;
    bus.pause = 1'b1;
    cycle();
    bus.start = 1'b0;
    repeat (5) cycle();
    bus.pause = 1'b0;

    // Pause for 10 cycles mid-second: the tick arrives exactly 10 cycles late.
    cycle();
    cycle();
    bus.pause = 1'b1;
    k = 0;
    repeat (10) begin cycle(); k++; end
    bus.pause = 1'b0;
    while (bus.dig0 == 4'(TOTAL % 10) && k < 100) begin cycle(); k++; end
    check("pause_delay", k, 10 + CPS - 2);

    // Door opened during WASH: alarm next cycle and freeze; close to resume.
    for (int i = 0; i < 200 && bus.phase != 3'd2; i++) cycle();
    check("reach_wash", bus.phase, 2);
    bus.door_open = 1'b1;
    cycle();
    check("alarm_rise", bus.alarm, 1);
    repeat (5) cycle();
    bus.door_open = 1'b0;
    cycle();
    check("alarm_fall", bus.alarm, 0);
    repeat (CPS + 2) cycle();

    // Randomized operator activity.
    for (int i = 0; i < 600; i++) begin
      bus.start     = ($urandom % 8) == 0;
      bus.pause     = ($urandom % 6) == 0;
      bus.door_open = ($urandom % 12) == 0;
      cycle();
    end
    bus.start = 1'b0; bus.pause = 1'b0; bus.door_open = 1'b0;

    // Reset pulse during DRAIN.
    for (int i = 0; i < 500 && bus.phase != 3'd4; i++) begin
      bus.start = !bus.busy;
      cycle();
    end
    bus.start = 1'b0;
    check("reach_drain", bus.phase, 4);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("rst_phase", bus.phase, 0);
    check("rst_level", bus.level, 0);

    // door_open blocks start in IDLE.
    bus.door_open = 1'b1;
    bus.start = 1'b1;
    cycle();
    check("door_blocks_start", bus.phase, 0);
    bus.start = 1'b0;
    bus.door_open = 1'b0;
    cycle();

    // TOTAL=100 build: 100 -> 099 on the first tick.
    bus2.start = 1'b1;
    cycle();
    bus2.start = 1'b0;
    check("b100_d2", bus2.dig2, 1);
    check("b100_d1", bus2.dig1, 0);
    check("b100_d0", bus2.dig0, 0);
    cycle();
    cycle();
    check("b099_d2", bus2.dig2, 0);
    check("b099_d1", bus2.dig1, 9);
    check("b099_d0", bus2.dig0, 9);
    check("b099_level", bus2.level, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/wash_ctrl.md
# wash_ctrl

Parametrised wash-cycle sequencer: the next generation of the single-program washer controller. It runs a fixed phase sequence (FILL, WASH, optional RINSE, DRAIN, SPIN), each phase lasting a parametrised number of seconds. It maintains a 3-digit BCD countdown of total remaining seconds, a 0..LEVEL_MAX water level and a thermometer phase bar. It supports start, pause and a door interlock. Digit outputs feed the existing 4-digit scanner; `st_light` drives the board LEDs.

## Interface
- `CLKS_PER_SEC`, 100000000: clk cycles per 1 s tick; ≥ 2.
- `FILL_S`, 10: FILL duration, s; ≥ 1.
- `WASH_S`, 40: WASH duration, s; ≥ 1.
- `RINSE_S`, 20: RINSE duration, s; ≥ 1; used only with `WASH_RINSE_EN`.
- `DRAIN_S`, 10: DRAIN duration, s; ≥ 1.
- `SPIN_S`, 20: SPIN duration, s; ≥ 1.
- `LEVEL_MAX`, 9: full water level; 1..15.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  level; sampled each cycle in IDLE/DONE.
- `pause`  in  1  level; high freezes a running cycle.
- `door_open`  in  1  level; high blocks start and freezes a running cycle.
- `dig2`, `dig1`, `dig0`  out  4 each  remaining seconds, BCD hundreds/tens/ones.
- `level`  out  4  water level, binary.
- `phase`  out  3  IDLE=0, FILL=1, WASH=2, RINSE=3, DRAIN=4, SPIN=5, DONE=6.
- `st_light`  out  8  thermometer: low `phase` bits set, others 0.
- `busy`  out  1  phase in 1..5.
- `done`  out  1  phase==DONE.
- `alarm`  out  1  busy & door_open, registered.

## Operation
- TOTAL = FILL_S+WASH_S+DRAIN_S+SPIN_S (+RINSE_S if enabled); must be ≤ 999 (elaboration-time check, `$error`).
- Reset values: phase=IDLE, digits=BCD(TOTAL), level=0, st_light=0, busy=0, done=0, alarm=0, prescaler=0.
- IDLE/DONE: `start`=1 with `door_open`=0 → FILL. Same edge: prescaler=0, phase timer=FILL_S, digits=BCD(TOTAL), level=0. Otherwise hold. `start` is ignored while busy.
- run = busy & !pause & !door_open. The prescaler advances only when run=1. tick = run & prescaler==CLKS_PER_SEC-1; prescaler wraps to 0 on tick.
- Each tick: BCD countdown −1, with per-digit borrow (0→9 borrows; e.g. 100→099); phase timer −1.
- Level per tick: FILL +1, saturating at LEVEL_MAX. WASH/RINSE hold. DRAIN −1, saturating at 0. SPIN forces 0.
- Phase transition: on a tick with phase timer==1 → next phase, timer loads that phase's duration. WASH→RINSE→DRAIN with `WASH_RINSE_EN`, otherwise WASH→DRAIN. SPIN→DONE.
- Entering DONE: digits read 000 (the last tick reaches 0), level=0.
- pause/door_open mid-second: the prescaler holds its value. On resume the partial second continues and is not restarted.
- pause and door_open both high: same as either alone. `alarm` follows door_open only.
- start and pause both high in IDLE: cycle starts, then freezes on the next cycle.
- rst mid-cycle: all state returns to reset values on the next edge; no drain sequence.

## Timing
- All outputs registered; they change only on `clk` rising edges.
- start → phase=FILL, busy=1: 1 cycle.
- First tick: CLKS_PER_SEC run-cycles after the start edge.
- Digits, level, phase and st_light update on the same edge as the tick that causes them.
- alarm: 1 cycle after door_open rises while busy.
- done asserts on the edge of the final tick and holds until start or rst.

## Configuration
- `WASH_RINSE_EN` defined: RINSE phase (code 3, level held, RINSE_S s) is inserted between WASH and DRAIN, and RINSE_S is included in TOTAL.
- `WASH_RINSE_EN` undefined: code 3 is never produced, RINSE_S is ignored, and st_light jumps 0x03→0x0F at WASH→DRAIN.

## Test plan
- CLKS_PER_SEC=4, FILL=3, WASH=2, RINSE=2, DRAIN=3, SPIN=2, LEVEL_MAX=2, rinse enabled; pulse start → phases 1,2,3,4,5,6 at ticks 3,5,7,10,12; digits 012→000; level 1,2,2,…,2,1,0,0; done at cycle 1+48.
- Same build without the macro → TOTAL=010, no phase 3, st_light 0x03→0x0F, done after 40 cycles.
- Raise pause for 10 cycles in the middle of a second → all outputs frozen; the following tick arrives exactly 10 cycles late.
- door_open=1 in IDLE with start → stays IDLE. door_open raised during WASH → alarm=1 next cycle, freeze; lower it → alarm=0 and resume.
- TOTAL=100 build → digits 1,0,0 → 0,9,9 on the first tick (borrow across two digits).
- rst pulse during DRAIN → next cycle phase=0, level=0, digits=BCD(TOTAL), alarm=0. Start from DONE → new cycle begins.
